// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the par2ser gearbox.
// Buffer states, counter width and symbol slice base computation.
package par2ser_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic int cnt_width(input int ratio);
        return (ratio >= 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic int sym_base(input int cnt, input int ratio,
                                    input logic msb, input int w);
        return msb ? (ratio - 1 - cnt) * w : cnt * w;
    endfunction

endpackage

// File: rtl/par2ser_gearbox_counter.sv
// Modulo-RATIO symbol counter with enable and synchronous clear.
// cnt_last flags the final symbol slot of the current word.
module p2s_sym_counter
    import par2ser_pkg::*;
#(
    parameter int RATIO = 8,
    parameter int CNT_W = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_last
);

    assign cnt_last = (cnt == CNT_W'(RATIO - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/par2ser_gearbox.sv
// Parallel-to-serial gearbox: two-word buffer, one symbol per cycle.
// Optional frame-last tracking is enabled with the P2S_LAST_EN macro.
module par2ser_gearbox
    import par2ser_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msb_first,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_last,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_last,
    output logic              dout_vld,
    input  logic              dout_rdy
);

    localparam int RATIO = DIN_W / DOUT_W;
    localparam int CNT_W = cnt_width(RATIO);

    state_t           state;
    state_t           state_n;
    logic [DIN_W-1:0] shift_q;
    logic [DIN_W-1:0] pend_q;
    logic             shift_msb;
    logic             pend_msb;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             accept;
    logic             emit;
    logic             final_pop;
    logic             ld_shift_din;
    logic             ld_shift_pend;
    logic             ld_pend;
    int               base;

    assign dout_vld  = (state != ST_EMPTY);
    assign accept    = din_vld & din_rdy;
    assign emit      = dout_vld & dout_rdy;
    assign final_pop = emit & cnt_last;

    p2s_sym_counter #(
        .RATIO (RATIO),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .clr      (rst),
        .en       (emit),
        .cnt      (cnt),
        .cnt_last (cnt_last)
    );

    always_comb begin
        state_n       = state;
        ld_shift_din  = 1'b0;
        ld_shift_pend = 1'b0;
        ld_pend       = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    ld_shift_din = 1'b1;
                    state_n      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !final_pop) begin
                    ld_pend = 1'b1;
                    state_n = ST_TWO;
                end else if (accept) begin
                    ld_shift_din = 1'b1;
                end else if (final_pop) begin
                    state_n = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (final_pop) begin
                    ld_shift_pend = 1'b1;
                    state_n       = ST_ONE;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // din_rdy is registered from the next state so dout_rdy never reaches it
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            din_rdy <= 1'b1;
        end else begin
            state   <= state_n;
            din_rdy <= (state_n != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            pend_q    <= '0;
            shift_msb <= 1'b0;
            pend_msb  <= 1'b0;
        end else begin
            if (ld_shift_din) begin
                shift_q   <= din;
                shift_msb <= msb_first;
            end else if (ld_shift_pend) begin
                shift_q   <= pend_q;
                shift_msb <= pend_msb;
            end
            if (ld_pend) begin
                pend_q   <= din;
                pend_msb <= msb_first;
            end
        end
    end

    always_comb base = sym_base(int'(cnt), RATIO, shift_msb, DOUT_W);
    assign dout = shift_q[base +: DOUT_W];

`ifdef P2S_LAST_EN
    logic shift_last;
    logic pend_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_last <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            if (ld_shift_din) begin
                shift_last <= din_last;
            end else if (ld_shift_pend) begin
                shift_last <= pend_last;
            end
            if (ld_pend) begin
                pend_last <= din_last;
            end
        end
    end

    assign dout_last = shift_last & cnt_last & dout_vld;
`else
    logic unused_last;
    assign unused_last = din_last;
    assign dout_last   = 1'b0;
`endif

endmodule

// File: tb/tb_par2ser_gearbox.sv
// Bench for par2ser_gearbox: 8->1 and 16->4 instances against a
// symbol-queue reference model.
module tb_par2ser_gearbox;

    localparam int AR = 8;
    localparam int BR = 4;
`ifdef P2S_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_msb, a_dlast, a_dvld, a_drdy, a_ovld, a_olast, a_ordy;
    logic [7:0]  a_din;
    logic [0:0]  a_dout;
    logic        b_msb, b_dlast, b_dvld, b_drdy, b_ovld, b_olast, b_ordy;
    logic [15:0] b_din;
    logic [3:0]  b_dout;

    par2ser_gearbox #(.DIN_W(8), .DOUT_W(1)) u_a (
        .clk(clk), .rst(rst), .msb_first(a_msb), .din(a_din),
        .din_last(a_dlast), .din_vld(a_dvld), .din_rdy(a_drdy),
        .dout(a_dout), .dout_last(a_olast), .dout_vld(a_ovld),
        .dout_rdy(a_ordy));

    par2ser_gearbox #(.DIN_W(16), .DOUT_W(4)) u_b (
        .clk(clk), .rst(rst), .msb_first(b_msb), .din(b_din),
        .din_last(b_dlast), .din_vld(b_dvld), .din_rdy(b_drdy),
        .dout(b_dout), .dout_last(b_olast), .dout_vld(b_ovld),
        .dout_rdy(b_ordy));

    typedef struct {
        logic [3:0] sym;
        logic       last;
    } sym_t;

    sym_t qa[$];
    sym_t qb[$];
    int   total = 0;
    int   bad   = 0;

    logic       a_acc, a_emit, a_spur, a_vld_s, a_rdy_s, a_last_s, a_exp_last;
    logic [3:0] a_obs, a_exp;
    logic       b_acc, b_emit, b_spur, b_vld_s, b_rdy_s, b_last_s, b_exp_last;
    logic [3:0] b_obs, b_exp;

    // Reference model: a word expands into RATIO symbols in the chosen order
    task automatic push_a(input logic [7:0] w, input logic m, input logic l);
        sym_t s;
        int   i;
        for (int k = 0; k < AR; k++) begin
            i      = m ? AR - 1 - k : k;
            s.sym  = {3'b000, w[i]};
            s.last = LAST_EN && l && (k == AR - 1);
            qa.push_back(s);
        end
    endtask

    task automatic push_b(input logic [15:0] w, input logic m, input logic l);
        sym_t s;
        int   i;
        for (int k = 0; k < BR; k++) begin
            i      = m ? BR - 1 - k : k;
            s.sym  = w[i*4 +: 4];
            s.last = LAST_EN && l && (k == BR - 1);
            qb.push_back(s);
        end
    endtask

    task automatic cyc_a(input logic v, input logic [7:0] d, input logic m,
                         input logic l, input logic r);
        a_dvld = v; a_din = d; a_msb = m; a_dlast = l; a_ordy = r;
        #3;
        a_acc    = a_dvld & a_drdy;
        a_emit   = a_ovld & a_ordy;
        a_vld_s  = a_ovld;
        a_rdy_s  = a_drdy;
        a_obs    = {3'b000, a_dout};
        a_last_s = a_olast;
        a_spur   = 1'b0;
        if (a_emit) begin
            if (qa.size() == 0) begin
                a_spur = 1'b1;
            end else begin
                a_exp      = qa[0].sym;
                a_exp_last = qa[0].last;
                void'(qa.pop_front());
            end
        end
        if (a_acc) push_a(d, m, l);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic v, input logic [15:0] d, input logic m,
                         input logic l, input logic r);
        b_dvld = v; b_din = d; b_msb = m; b_dlast = l; b_ordy = r;
        #3;
        b_acc    = b_dvld & b_drdy;
        b_emit   = b_ovld & b_ordy;
        b_vld_s  = b_ovld;
        b_rdy_s  = b_drdy;
        b_obs    = b_dout;
        b_last_s = b_olast;
        b_spur   = 1'b0;
        if (b_emit) begin
            if (qb.size() == 0) begin
                b_spur = 1'b1;
            end else begin
                b_exp      = qb[0].sym;
                b_exp_last = qb[0].last;
                void'(qb.pop_front());
            end
        end
        if (b_acc) push_b(d, m, l);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 8;
        if (a_ovld !== 1'b0) begin bad++; $display("FAIL rst_a_vld got %b want 0", a_ovld); end
        if (a_drdy !== 1'b1) begin bad++; $display("FAIL rst_a_rdy got %b want 1", a_drdy); end
        if (a_dout !== 1'b0) begin bad++; $display("FAIL rst_a_dout got %h want 0", a_dout); end
        if (a_olast !== 1'b0) begin bad++; $display("FAIL rst_a_last got %b want 0", a_olast); end
        if (b_ovld !== 1'b0) begin bad++; $display("FAIL rst_b_vld got %b want 0", b_ovld); end
        if (b_drdy !== 1'b1) begin bad++; $display("FAIL rst_b_rdy got %b want 1", b_drdy); end
        if (b_dout !== 4'h0) begin bad++; $display("FAIL rst_b_dout got %h want 0", b_dout); end
        if (b_olast !== 1'b0) begin bad++; $display("FAIL rst_b_last got %b want 0", b_olast); end
        rst = 1'b0;
    endtask

    task automatic test_single(input logic [7:0] w, input logic m);
        logic [7:0] got;
        int         n;
        got = '0;
        n   = 0;
        cyc_a(1'b1, w, m, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (a_emit) begin
                total++;
                if (a_spur || a_obs !== a_exp || a_last_s !== a_exp_last) begin
                    bad++;
                    $display("FAIL single_sym got %h/%b want %h/%b", a_obs, a_last_s, a_exp, a_exp_last);
                end
                if (n < 8) got[m ? 7 - n : n] = a_obs[0];
                n++;
            end
        end
        total += 3;
        if (got !== w) begin bad++; $display("FAIL single_word got %h want %h", got, w); end
        if (n != 8) begin bad++; $display("FAIL single_count got %0d want 8", n); end
        if (a_vld_s !== 1'b0) begin bad++; $display("FAIL single_idle got %b want 0", a_vld_s); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3] = '{8'h01, 8'h80, 8'hFF};
        int idx = 0;
        int n = 0;
        int first = -1;
        int lastc = -1;
        for (int c = 0; c < 40; c++) begin
            cyc_a(idx < 3, (idx < 3) ? w[idx] : 8'h00, 1'b0, 1'b0, 1'b1);
            if (a_acc) idx++;
            if (a_emit) begin
                total++;
                if (a_spur || a_obs !== a_exp || a_last_s !== a_exp_last) begin
                    bad++;
                    $display("FAIL b2b_sym got %h want %h", a_obs, a_exp);
                end
                if (first < 0) first = c;
                lastc = c;
                n++;
            end
        end
        total += 3;
        if (idx != 3) begin bad++; $display("FAIL b2b_accepts got %0d want 3", idx); end
        if (n != 24) begin bad++; $display("FAIL b2b_count got %0d want 24", n); end
        if (lastc - first + 1 != 24) begin
            bad++;
            $display("FAIL b2b_bubble got span %0d want 24", lastc - first + 1);
        end
    endtask

    task automatic test_stall16();
        logic [15:0] got;
        logic [3:0]  prev;
        logic        prev_stall;
        int          n;
        got = '0;
        n = 0;
        prev = '0;
        prev_stall = 1'b0;
        cyc_b(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cyc_b(1'b0, 16'h0000, 1'b0, 1'b0, c[0]);
            if (prev_stall) begin
                total++;
                if (!b_vld_s || b_obs !== prev) begin
                    bad++;
                    $display("FAIL stall_hold got %h/%b want %h/1", b_obs, b_vld_s, prev);
                end
            end
            if (b_emit) begin
                total++;
                if (b_spur || b_obs !== b_exp || b_last_s !== b_exp_last) begin
                    bad++;
                    $display("FAIL stall_sym got %h want %h", b_obs, b_exp);
                end
                if (n < 4) got[n*4 +: 4] = b_obs;
                n++;
            end
            prev_stall = b_vld_s & ~b_ordy;
            prev = b_obs;
        end
        total += 2;
        if (got !== 16'h1234) begin bad++; $display("FAIL stall_word got %h want 1234", got); end
        if (n != 4) begin bad++; $display("FAIL stall_count got %0d want 4", n); end
    endtask

    task automatic test_fill();
        logic [7:0] w;
        logic       m;
        int         acc;
        int         n;
        w = 8'($urandom);
        m = 1'($urandom);
        acc = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            cyc_a(1'b1, w, m, 1'b0, 1'b0);
            if (a_acc) begin
                acc++;
                w = 8'($urandom);
                m = 1'($urandom);
            end
        end
        total += 2;
        if (acc != 2) begin bad++; $display("FAIL fill_accepts got %0d want 2", acc); end
        if (a_rdy_s !== 1'b0) begin bad++; $display("FAIL fill_rdy got %b want 0", a_rdy_s); end
        for (int c = 0; c < 24; c++) begin
            cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (a_emit) begin
                total++;
                if (a_spur || a_obs !== a_exp || a_last_s !== a_exp_last) begin
                    bad++;
                    $display("FAIL fill_sym got %h want %h", a_obs, a_exp);
                end
                n++;
            end
        end
        total += 2;
        if (n != 16) begin bad++; $display("FAIL fill_count got %0d want 16", n); end
        if (qa.size() != 0) begin bad++; $display("FAIL fill_left got %0d want 0", qa.size()); end
    endtask

    task automatic test_last_and_reset();
        int n = 0;
        int hits = 0;
        int pos = 0;
        int idx = 0;
        for (int c = 0; c < 24; c++) begin
            cyc_a(idx < 2, 8'($urandom), 1'b0, idx == 1, 1'b1);
            if (a_acc) idx++;
            if (a_emit) begin
                n++;
                total++;
                if (a_spur || a_obs !== a_exp || a_last_s !== a_exp_last) begin
                    bad++;
                    $display("FAIL last_sym got %h/%b want %h/%b", a_obs, a_last_s, a_exp, a_exp_last);
                end
            end
            if (a_last_s) begin
                hits++;
                pos = n;
            end
        end
        total += 2;
        if (hits != (LAST_EN ? 1 : 0)) begin
            bad++;
            $display("FAIL last_hits got %0d want %0d", hits, LAST_EN ? 1 : 0);
        end
        if (pos != (LAST_EN ? 16 : 0)) begin
            bad++;
            $display("FAIL last_pos got %0d want %0d", pos, LAST_EN ? 16 : 0);
        end
        cyc_a(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total += 2;
        if (a_ovld !== 1'b0) begin bad++; $display("FAIL midrst_vld got %b want 0", a_ovld); end
        if (a_drdy !== 1'b1) begin bad++; $display("FAIL midrst_rdy got %b want 1", a_drdy); end
        rst = 1'b0;
        qa.delete();
    endtask

    task automatic test_random();
        logic [7:0]  wa;
        logic [15:0] wb;
        logic        ma, mb;
        wa = 8'($urandom);
        ma = 1'($urandom);
        for (int c = 0; c < 340; c++) begin
            cyc_a(c < 300 && ($urandom_range(3) != 0), wa, ma, 1'($urandom),
                  c >= 300 || ($urandom_range(2) != 0));
            if (a_acc) begin
                wa = 8'($urandom);
                ma = 1'($urandom);
            end
            if (a_emit) begin
                total++;
                if (a_spur || a_obs !== a_exp || a_last_s !== a_exp_last) begin
                    bad++;
                    $display("FAIL rnd_a got %h/%b want %h/%b", a_obs, a_last_s, a_exp, a_exp_last);
                end
            end
        end
        wb = 16'($urandom);
        mb = 1'($urandom);
        for (int c = 0; c < 340; c++) begin
            cyc_b(c < 300 && ($urandom_range(3) != 0), wb, mb, 1'($urandom),
                  c >= 300 || ($urandom_range(2) != 0));
            if (b_acc) begin
                wb = 16'($urandom);
                mb = 1'($urandom);
            end
            if (b_emit) begin
                total++;
                if (b_spur || b_obs !== b_exp || b_last_s !== b_exp_last) begin
                    bad++;
                    $display("FAIL rnd_b got %h/%b want %h/%b", b_obs, b_last_s, b_exp, b_exp_last);
                end
            end
        end
        total += 2;
        if (qa.size() != 0) begin bad++; $display("FAIL rnd_a_left got %0d want 0", qa.size()); end
        if (qb.size() != 0) begin bad++; $display("FAIL rnd_b_left got %0d want 0", qb.size()); end
    endtask

    initial begin
        a_msb = 0; a_dlast = 0; a_dvld = 0; a_ordy = 0; a_din = '0;
        b_msb = 0; b_dlast = 0; b_dvld = 0; b_ordy = 0; b_din = '0;
        a_exp = '0; a_exp_last = 0; b_exp = '0; b_exp_last = 0;
        test_reset();
        test_single(8'hA5, 1'b0);
        test_single(8'h3C, 1'b1);
        test_back_to_back();
        test_stall16();
        test_fill();
        test_last_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
